// File: rtl/param_updown_counter.sv
`default_nettype none
// ============================================================================
// param_updown_counter: parametrised up/down counter with enable prescaler,
// wrap/saturate boundaries, terminal-count pulse and sticky overflow flag.
// Revision: 1.0
// ============================================================================
module param_updown_counter #(
    parameter int WIDTH     = 8,
    parameter int MAX_VALUE = 255,
    parameter int PRESCALE  = 1,
    parameter int SATURATE  = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             clear,
    output logic [WIDTH-1:0] q,
    output logic             tick,
    output logic             tc,
    output logic             ovf
);

    localparam int               PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [WIDTH-1:0] MAX_Q    = WIDTH'(MAX_VALUE);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);
    localparam bit               HOLD     = (SATURATE != 0);

    logic [PRE_W-1:0] pre;
    logic             step;
    logic             at_bound;
    logic [WIDTH-1:0] load_clamped;

    assign step         = enable && (pre == PRE_LAST);
    assign at_bound     = up ? (q == MAX_Q) : (q == '0);
    assign load_clamped = (load_value > MAX_Q) ? MAX_Q : load_value;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q    <= '0;
            pre  <= '0;
            tick <= 1'b0;
            tc   <= 1'b0;
            ovf  <= 1'b0;
        end else if (clear) begin
            q    <= '0;
            pre  <= '0;
            tick <= 1'b0;
            tc   <= 1'b0;
            ovf  <= 1'b0;
        end else if (load) begin
            q    <= load_clamped;
            pre  <= '0;
            tick <= 1'b0;
            tc   <= 1'b0;
        end else begin
            tick <= step;
            tc   <= step && at_bound;
            if (enable) begin
                pre <= step ? '0 : pre + 1'b1;
            end
            if (step) begin
                if (at_bound) begin
                    ovf <= 1'b1;
                    // Saturating mode leaves q untouched at the boundary.
                    if (!HOLD) begin
                        q <= up ? '0 : MAX_Q;
                    end
                end else begin
                    q <= up ? q + 1'b1 : q - 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_param_updown_counter.sv
`default_nettype none
// Bench: three counter configurations driven by shared stimulus, checked every
// cycle against an arithmetic model, plus literal checks from the test plan.
module tb_param_updown_counter;

    localparam int N = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0, up = 1'b0, load = 1'b0, clear = 1'b0;
    logic [7:0] lv = 8'd0;

    logic [3:0] qa, qb;
    logic [7:0] qc;
    logic       ticka, tca, ovfa, tickb, tcb, ovfb, tickc, tcc, ovfc;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    // A: decade wrap, B: decade saturate with prescale 3, C: defaults
    param_updown_counter #(.WIDTH(4), .MAX_VALUE(9), .PRESCALE(1), .SATURATE(0)) dut_a (
        .clk(clk), .reset(reset), .enable(enable), .up(up), .load(load),
        .load_value(lv[3:0]), .clear(clear), .q(qa), .tick(ticka), .tc(tca), .ovf(ovfa));
    param_updown_counter #(.WIDTH(4), .MAX_VALUE(9), .PRESCALE(3), .SATURATE(1)) dut_b (
        .clk(clk), .reset(reset), .enable(enable), .up(up), .load(load),
        .load_value(lv[3:0]), .clear(clear), .q(qb), .tick(tickb), .tc(tcb), .ovf(ovfb));
    param_updown_counter dut_c (
        .clk(clk), .reset(reset), .enable(enable), .up(up), .load(load),
        .load_value(lv), .clear(clear), .q(qc), .tick(tickc), .tc(tcc), .ovf(ovfc));

    function automatic int maxv(int k);
        return (k == 2) ? 255 : 9;
    endfunction
    function automatic int maskv(int k);
        return (k == 2) ? 255 : 15;
    endfunction
    function automatic int psv(int k);
        return (k == 1) ? 3 : 1;
    endfunction
    function automatic bit satv(int k);
        return (k == 1);
    endfunction

    typedef struct {
        int q;
        int pre;
        int tick;
        int tc;
        int ovf;
    } st_t;

    st_t m [N];

    function automatic st_t nxt(st_t s, int k);
        st_t n;
        int  mx;
        int  v;
        bit  bnd;
        n       = s;
        mx      = maxv(k);
        n.tick  = 0;
        n.tc    = 0;
        if (clear) begin
            n = '{default: 0};
        end else if (load) begin
            v     = int'(lv) & maskv(k);
            n.q   = (v > mx) ? mx : v;
            n.pre = 0;
        end else if (enable) begin
            n.pre = (s.pre + 1) % psv(k);
            if (n.pre == 0) begin
                bnd    = up ? (s.q == mx) : (s.q == 0);
                n.tick = 1;
                if (bnd) begin
                    n.tc  = 1;
                    n.ovf = 1;
                end
                if (bnd && satv(k)) n.q = s.q;
                else n.q = up ? (s.q + 1) % (mx + 1) : (s.q + mx) % (mx + 1);
            end
        end
        return n;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < N; k++) m[k] <= '{default: 0};
        end else begin
            for (int k = 0; k < N; k++) m[k] <= nxt(m[k], k);
        end
    end

    function automatic int dq(int k);
        return (k == 0) ? int'(qa) : (k == 1) ? int'(qb) : int'(qc);
    endfunction
    function automatic int dtick(int k);
        return (k == 0) ? int'(ticka) : (k == 1) ? int'(tickb) : int'(tickc);
    endfunction
    function automatic int dtc(int k);
        return (k == 0) ? int'(tca) : (k == 1) ? int'(tcb) : int'(tcc);
    endfunction
    function automatic int dovf(int k);
        return (k == 0) ? int'(ovfa) : (k == 1) ? int'(ovfb) : int'(ovfc);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Per-cycle comparison of every instance against the model
    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < N; k++) begin
                chk($sformatf("q[%0d]", k),    dq(k),    m[k].q);
                chk($sformatf("tick[%0d]", k), dtick(k), m[k].tick);
                chk($sformatf("tc[%0d]", k),   dtc(k),   m[k].tc);
                chk($sformatf("ovf[%0d]", k),  dovf(k),  m[k].ovf);
            end
        end
    end

    task automatic cyc(input bit en, input bit u, input bit ld, input bit cl, input int val, input int n);
        enable = en; up = u; load = ld; clear = cl; lv = 8'(val);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #1 reset = 1'b0;
        #3 chk_en = 1'b1;
        @(posedge clk); #1;
        chk("rst_q_c", int'(qc), 0);
        chk("rst_ovf_c", int'(ovfc), 0);
        #2 reset = 1'b1;
        // Decrement from reset: wraps to MAX with tc and ovf
        cyc(1, 0, 0, 0, 0, 1);
        chk("down_wrap_q_c", int'(qc), 255);
        chk("down_wrap_tc_c", int'(tcc), 1);
        chk("down_wrap_ovf_c", int'(ovfc), 1);
        chk("down_wrap_q_a", int'(qa), 9);
        chk("ps_no_step_tick_b", int'(tickb), 0);
        cyc(0, 0, 0, 1, 0, 1);
        // Count up through the decade
        cyc(1, 1, 0, 0, 0, 9);
        chk("up9_q_a", int'(qa), 9);
        chk("up9_tc_a", int'(tca), 0);
        cyc(1, 1, 0, 0, 0, 1);
        chk("up10_q_a", int'(qa), 0);
        chk("up10_tc_a", int'(tca), 1);
        chk("up10_ovf_a", int'(ovfa), 1);
        chk("up10_q_b", int'(qb), 3);
        chk("up10_q_c", int'(qc), 10);
        // Clamped load leaves ovf alone; clear beats load
        cyc(0, 1, 1, 0, 12, 1);
        chk("load_clamp_q_a", int'(qa), 9);
        chk("load_clamp_ovf_a", int'(ovfa), 1);
        chk("load_q_c", int'(qc), 12);
        cyc(0, 1, 1, 1, 12, 1);
        chk("load_clear_q_a", int'(qa), 0);
        chk("load_clear_ovf_a", int'(ovfa), 0);
        // Saturating decrement with prescale 3
        cyc(0, 0, 1, 0, 2, 1);
        cyc(1, 0, 0, 0, 0, 6);
        chk("sat_down_q_b", int'(qb), 0);
        chk("sat_down_tc_b", int'(tcb), 0);
        cyc(1, 0, 0, 0, 0, 3);
        chk("sat_hold1_tc_b", int'(tcb), 1);
        cyc(1, 0, 0, 0, 0, 3);
        chk("sat_hold2_q_b", int'(qb), 0);
        chk("sat_hold2_tc_b", int'(tcb), 1);
        chk("sat_ovf_b", int'(ovfb), 1);
        // Prescale with enable gaps
        cyc(0, 1, 0, 1, 0, 1);
        cyc(1, 1, 0, 0, 0, 4);
        cyc(0, 1, 0, 0, 0, 2);
        chk("gap_hold_q_b", int'(qb), 1);
        cyc(1, 1, 0, 0, 0, 5);
        chk("gap_q_b", int'(qb), 3);
        chk("gap_tick_b", int'(tickb), 1);
        // Reset mid-prescale
        cyc(0, 1, 1, 0, 5, 1);
        cyc(1, 1, 0, 0, 0, 1);
        chk("pre_mid_q_b", int'(qb), 5);
        reset = 1'b0;
        #1;
        chk("async_rst_q_b", int'(qb), 0);
        chk("async_rst_ovf_b", int'(ovfb), 0);
        #2 reset = 1'b1;
        cyc(1, 1, 0, 0, 0, 2);
        chk("after_rst2_q_b", int'(qb), 0);
        cyc(1, 1, 0, 0, 0, 1);
        chk("after_rst3_q_b", int'(qb), 1);
        chk("after_rst3_tick_b", int'(tickb), 1);
        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            enable = ($urandom_range(99) < 75);
            up     = ($urandom_range(99) < ((i / 500) % 2 == 0 ? 80 : 20));
            load   = ($urandom_range(99) < 4);
            clear  = ($urandom_range(99) < 2);
            lv     = 8'($urandom);
            if ($urandom_range(299) == 0) begin
                reset = 1'b0;
                #2 reset = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
